riscv_multicycle_controller: RTL and testbench

- Moore-style main FSM plus ALU and immediate decoders that sequence a multicycle RV32I datapath.
- The datapath uses one shared instruction/data memory, one ALU, and the IR, OldPC, ALUOut and Data registers.
- The block replaces the single-cycle combinational controller when the core moves to a shared-memory multicycle organisation.
- Supported instructions: lw, sw, R-type (add/sub/and/or/xor/slt), I-type ALU (addi/andi/ori/xori/slti), beq, bne, jal, lui.

---
 rtl/riscv_multicycle_controller.sv | 201 ++++++++++++++++++++
 tb/tb_riscv_multicycle_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32I main controller: Moore FSM plus ALU and immediate decoders.
// Optional MEM_WAIT_EN adds MemReady and stalls FETCH/MEMREAD/MEMWRITE until memory is ready.
module riscv_multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
`ifdef MEM_WAIT_EN
    input  logic               MemReady,
`endif
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [2:0]         ImmSrc,
    output logic               RegWrite,
    output logic               Retire,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 0,
        DECODE   = 1,
        MEMADR   = 2,
        MEMREAD  = 3,
        MEMWB    = 4,
        MEMWRITE = 5,
        EXECR    = 6,
        EXECI    = 7,
        ALUWB    = 8,
        BRANCH   = 9,
        JAL      = 10,
        LUI      = 11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_t;

    state_t state_q, state_d;
    aluop_t aluop;
    logic   mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = MemReady;
`else
    assign mem_ok = 1'b1;
`endif

    assign State = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = FETCH;
        aluop     = ALU_ADD;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        Retire    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ok;
                PCWrite   = mem_ok;
                state_d   = mem_ok ? DECODE : FETCH;
            end
            DECODE: begin
                // OldPC + ImmExt lands in ALUOut as the branch/jal target
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    7'b0110111:             state_d = LUI;
                    default: begin
                        state_d = FETCH;
                        Retire  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ok ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
            end
            MEMWRITE: begin
                // strobe held through a stall so the store data stays on the bus
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Retire   = mem_ok;
                state_d  = mem_ok ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = ALU_FUNCT;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = ALU_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                aluop   = ALU_SUB;
                Retire  = 1'b1;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = ~Zero;
                    default: PCWrite = 1'b0;
                endcase
            end
            JAL: begin
                // PC takes the DECODE target while the ALU forms the link value
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            LUI: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Retire   = 1'b0;
        end
    end

    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            ALU_SUB: ALUControl = 3'b001;
            ALU_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 3'b001;
            7'b1100011: ImmSrc = 3'b010;
            7'b1101111: ImmSrc = 3'b011;
            7'b0110111: ImmSrc = 3'b100;
            default:    ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench for riscv_multicycle_controller: per-cycle expected control vectors
// are queued by the driver and compared by a negedge monitor.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
`ifdef MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic [3:0] state;

  logic [21:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  im;

  always #5 clk = ~clk;

  riscv_multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .op(op),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .Zero(zero),
`ifdef MEM_WAIT_EN
    .MemReady(mem_ready),
`endif
    .PCWrite(pc_write),
    .AdrSrc(adr_src),
    .MemWrite(mem_write),
    .IRWrite(ir_write),
    .ResultSrc(result_src),
    .ALUSrcA(alu_src_a),
    .ALUSrcB(alu_src_b),
    .ALUControl(alu_control),
    .ImmSrc(imm_src),
    .RegWrite(reg_write),
    .Retire(retire),
    .State(state)
  );

  // field order: state, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ret
  function automatic logic [21:0] v(input logic [3:0] st, input logic pcw, input logic adr,
                                    input logic mw, input logic irw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] alu, input logic [2:0] imm,
                                    input logic rw, input logic ret);
    return {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ret};
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [21:0] act, e;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act = {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             alu_control, imm_src, reg_write, retire};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%b imm=%b rw=%b ret=%b, want st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%b imm=%b rw=%b ret=%b",
                 n, act[21:18], act[17], act[16], act[15], act[14], act[13:12], act[11:10],
                 act[9:8], act[7:5], act[4:2], act[1], act[0],
                 e[21:18], e[17], e[16], e[15], e[14], e[13:12], e[11:10],
                 e[9:8], e[7:5], e[4:2], e[1], e[0]);
      end
    end
  end

  // driver: one cycle with reset level and expected outputs
  task automatic cyc(input string nm, input logic rst, input logic [21:0] e);
    reset = rst;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic [2:0] imm);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; im = imm;
  endtask

  task automatic fetch_decode(input string nm, input logic illegal);
    cyc({nm, "_fetch"}, 1'b0, v(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, im, 0, 0));
    cyc({nm, "_decode"}, 1'b0, v(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, im, 0, illegal));
  endtask

  task automatic r_type(input string nm, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    set_instr(7'b0110011, f3, f7, 1'b0, 3'b000);
    fetch_decode(nm, 1'b0);
    cyc({nm, "_execr"}, 1'b0, v(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, im, 0, 0));
    cyc({nm, "_aluwb"}, 1'b0, v(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1, 1));
  endtask

  task automatic i_type(input string nm, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    set_instr(7'b0010011, f3, f7, 1'b0, 3'b000);
    fetch_decode(nm, 1'b0);
    cyc({nm, "_execi"}, 1'b0, v(4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, im, 0, 0));
    cyc({nm, "_aluwb"}, 1'b0, v(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1, 1));
  endtask

  task automatic branch(input string nm, input logic [2:0] f3, input logic z, input logic pcw);
    set_instr(7'b1100011, f3, 1'b0, z, 3'b010);
    fetch_decode(nm, 1'b0);
    cyc({nm, "_branch"}, 1'b0, v(4'd9, pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, im, 0, 1));
  endtask

  initial begin
    reset = 1'b1;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1;

    // reset held 3 cycles starting in EXECR
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000);
    fetch_decode("rst_add", 1'b0);
    cyc("rst_in_execr", 1'b1, v(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, im, 0, 0));
    cyc("rst_fetch_a", 1'b1, v(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, im, 0, 0));
    cyc("rst_fetch_b", 1'b1, v(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, im, 0, 0));
    r_type("post_rst_add", 3'b000, 1'b0, 3'b000);

    // lw
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000);
    fetch_decode("lw", 1'b0);
    cyc("lw_memadr", 1'b0, v(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0, 0));
    cyc("lw_memread", 1'b0, v(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 0));
    cyc("lw_memwb", 1'b0, v(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, im, 1, 1));

    // sw
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b001);
    fetch_decode("sw", 1'b0);
    cyc("sw_memadr", 1'b0, v(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0, 0));
    cyc("sw_memwrite", 1'b0, v(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 1));

    // ALU decode
    r_type("add", 3'b000, 1'b0, 3'b000);
    r_type("sub", 3'b000, 1'b1, 3'b001);
    i_type("addi_f7", 3'b000, 1'b1, 3'b000);
    r_type("and", 3'b111, 1'b0, 3'b010);
    r_type("xor", 3'b100, 1'b0, 3'b100);
    r_type("slt", 3'b010, 1'b0, 3'b101);
    r_type("sll_unsup", 3'b001, 1'b0, 3'b000);
    i_type("ori", 3'b110, 1'b0, 3'b011);
    i_type("slti", 3'b010, 1'b0, 3'b101);

    // branches
    branch("beq_taken", 3'b000, 1'b1, 1'b1);
    branch("beq_not", 3'b000, 1'b0, 1'b0);
    branch("bne_taken", 3'b001, 1'b0, 1'b1);
    branch("bne_not", 3'b001, 1'b1, 1'b0);
    branch("blt_unsup", 3'b100, 1'b1, 1'b0);

    // jal, lui, illegal
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 3'b011);
    fetch_decode("jal", 1'b0);
    cyc("jal_jal", 1'b0, v(4'd10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, im, 0, 0));
    cyc("jal_aluwb", 1'b0, v(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1, 1));

    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 3'b100);
    fetch_decode("lui", 1'b0);
    cyc("lui_lui", 1'b0, v(4'd11, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b000, im, 1, 1));

    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 3'b000);
    fetch_decode("illegal", 1'b1);
    r_type("after_illegal", 3'b110, 1'b0, 3'b011);

`ifdef MEM_WAIT_EN
    // FETCH stalled 2 cycles, then a store stalled 1 cycle in MEMWRITE
    set_instr(7'b0100011, 3'b000, 1'b0, 1'b0, 3'b001);
    mem_ready = 1'b0;
    cyc("wait_fetch_a", 1'b0, v(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, im, 0, 0));
    cyc("wait_fetch_b", 1'b0, v(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, im, 0, 0));
    mem_ready = 1'b1;
    fetch_decode("wait_sw", 1'b0);
    cyc("wait_sw_memadr", 1'b0, v(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0, 0));
    mem_ready = 1'b0;
    cyc("wait_sw_hold", 1'b0, v(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 0));
    mem_ready = 1'b1;
    cyc("wait_sw_done", 1'b0, v(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 1));
    r_type("wait_after", 3'b000, 1'b0, 3'b000);
`endif

    repeat (5) if (exp_q.size() > 0) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
